// File: rtl/rptr_empty_lvl_if.sv
// Read-side bundle of the async FIFO pointer block: read controls in, pointer/status out.
// Revision: 1.0
`default_nettype none

interface rptr_empty_lvl_if #(
  parameter int ADDRSIZE = 4
);
  logic                rinc;
  logic                rflush;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rcount;
  logic                ruflow;

  modport master (
    output rinc, rflush, rq2_wptr,
    input  raddr, rptr, rempty, raempty, rcount, ruflow
  );

  modport slave (
    input  rinc, rflush, rq2_wptr,
    output raddr, rptr, rempty, raempty, rcount, ruflow
  );
endinterface

`default_nettype wire

// File: rtl/rptr_empty_lvl.sv
// ============================================================================
// rptr_empty_lvl : read-domain pointer, empty/almost-empty flags, fill level,
//                  flush and optional sticky underflow (RPTR_EMPTY_UFLOW_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module rptr_empty_lvl #(
  parameter int ADDRSIZE  = 4,
  parameter int AE_THRESH = 2
) (
  input  wire logic           rclk,
  input  wire logic           rrst_n,
  rptr_empty_lvl_if.slave     bus
);
  localparam logic [ADDRSIZE:0] c_AE_THRESH = (ADDRSIZE + 1)'(AE_THRESH);

  logic [ADDRSIZE:0] r_rbin;
  logic [ADDRSIZE:0] r_rptr;
  logic [ADDRSIZE:0] r_rcount;
  logic              r_rempty;
  logic              r_raempty;

  logic [ADDRSIZE:0] w_rq2_wbin;
  logic [ADDRSIZE:0] w_rbinnext;
  logic [ADDRSIZE:0] w_rgraynext;
  logic [ADDRSIZE:0] w_lvlnext;
  logic              w_pop;

  // Gray-to-binary: bit i is the XOR of all Gray bits from i upward.
  always_comb begin
    w_rq2_wbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      w_rq2_wbin[i] = ^(bus.rq2_wptr >> i);
    end
  end

  assign w_pop       = bus.rinc & ~r_rempty & ~bus.rflush;
  assign w_rbinnext  = bus.rflush ? w_rq2_wbin
                                  : r_rbin + {{ADDRSIZE{1'b0}}, w_pop};
  assign w_rgraynext = (w_rbinnext >> 1) ^ w_rbinnext;
  assign w_lvlnext   = w_rq2_wbin - w_rbinnext;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rbin    <= '0;
      r_rptr    <= '0;
      r_rcount  <= '0;
      r_rempty  <= 1'b1;
      r_raempty <= 1'b1;
    end else begin
      r_rbin    <= w_rbinnext;
      r_rptr    <= w_rgraynext;
      r_rcount  <= w_lvlnext;
      r_rempty  <= (w_rgraynext == bus.rq2_wptr);
      r_raempty <= (w_lvlnext <= c_AE_THRESH);
    end
  end

`ifdef RPTR_EMPTY_UFLOW_EN
  logic r_ruflow;

  // Flush clears with priority over a same-cycle underflow attempt.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_ruflow <= 1'b0;
    end else if (bus.rflush) begin
      r_ruflow <= 1'b0;
    end else if (bus.rinc && r_rempty) begin
      r_ruflow <= 1'b1;
    end
  end

  assign bus.ruflow = r_ruflow;
`else
  assign bus.ruflow = 1'b0;
`endif

  assign bus.raddr   = r_rbin[ADDRSIZE-1:0];
  assign bus.rptr    = r_rptr;
  assign bus.rempty  = r_rempty;
  assign bus.raempty = r_raempty;
  assign bus.rcount  = r_rcount;

endmodule

`default_nettype wire

// File: tb/tb_rptr_empty_lvl.sv
// Scoreboard bench for rptr_empty_lvl (ADDRSIZE=4, AE_THRESH=2).
// Revision: 1.0
`default_nettype none

module tb_rptr_empty_lvl;
  localparam int AW = 4;

`ifdef RPTR_EMPTY_UFLOW_EN
  localparam logic UF = 1'b1;
`else
  localparam logic UF = 1'b0;
`endif

  typedef struct {
    logic         empty;
    logic         aempty;
    logic [AW:0]  count;
    logic [AW-1:0] raddr;
    logic [AW:0]  rptr;
    logic         uflow;
  } exp_t;

  logic rclk;
  logic rrst_n;
  exp_t q[$];
  int   n_tests;
  int   n_fail;

  rptr_empty_lvl_if #(.ADDRSIZE(AW)) bus ();

  rptr_empty_lvl #(.ADDRSIZE(AW), .AE_THRESH(2)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus.slave)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return (v >> 1) ^ v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input exp_t e);
    check("rempty",  int'(bus.rempty),  int'(e.empty));
    check("raempty", int'(bus.raempty), int'(e.aempty));
    check("rcount",  int'(bus.rcount),  int'(e.count));
    check("raddr",   int'(bus.raddr),   int'(e.raddr));
    check("rptr",    int'(bus.rptr),    int'(e.rptr));
    check("ruflow",  int'(bus.ruflow),  int'(e.uflow));
  endtask

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input logic inc, input logic fl, input logic [AW:0] wptr,
                      input logic e_empty, input logic e_ae, input int e_cnt,
                      input int e_addr, input logic [AW:0] e_rptr, input logic e_uf);
    exp_t e;
    @(posedge rclk);
    #2;
    bus.rinc     = inc;
    bus.rflush   = fl;
    bus.rq2_wptr = wptr;
    e.empty  = e_empty;
    e.aempty = e_ae;
    e.count  = e_cnt[AW:0];
    e.raddr  = e_addr[AW-1:0];
    e.rptr   = e_rptr;
    e.uflow  = e_uf;
    q.push_back(e);
  endtask

  task automatic reset_check();
    exp_t e;
    e.empty = 1'b1; e.aempty = 1'b1; e.count = '0;
    e.raddr = '0;   e.rptr = '0;     e.uflow = 1'b0;
    check_all(e);
  endtask

  // Monitor: one expectation retired per clock, sampled 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge rclk);
      #1;
      if (q.size() != 0) check_all(q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rrst_n       = 1'b0;
    bus.rinc     = 1'b0;
    bus.rflush   = 1'b0;
    bus.rq2_wptr = '0;
    repeat (2) @(posedge rclk);
    #1 reset_check();
    @(negedge rclk) rrst_n = 1'b1;

    // Three words arrive, then pop down through the almost-empty threshold.
    step(0, 0, gray(3), 0, 0, 3, 0, 5'b00000, 0);
    step(1, 0, gray(3), 0, 1, 2, 1, 5'b00001, 0);
    step(1, 0, gray(3), 0, 1, 1, 2, 5'b00011, 0);
    // Pop together with a write-pointer increment: level holds at 1.
    step(1, 0, gray(4), 0, 1, 1, 3, 5'b00010, 0);
    step(1, 0, gray(4), 1, 1, 0, 4, 5'b00110, 0);
    // Read while empty: pointer holds, underflow becomes sticky.
    step(1, 0, gray(4), 1, 1, 0, 4, 5'b00110, UF);
    step(0, 0, gray(4), 1, 1, 0, 4, 5'b00110, UF);
    step(0, 1, gray(4), 1, 1, 0, 4, 5'b00110, 0);
    // Level 5, then flush with rinc: jump to write pointer, no pop.
    step(0, 0, gray(9), 0, 0, 5, 4, 5'b00110, 0);
    step(1, 1, gray(9), 1, 1, 0, 9, 5'b01101, 0);
    step(0, 0, gray(12), 0, 0, 3, 9, 5'b01101, 0);

    // Asynchronous reset mid-operation.
    @(posedge rclk);
    #3 rrst_n = 1'b0;
    #1 reset_check();
    bus.rq2_wptr = '0;
    @(negedge rclk) rrst_n = 1'b1;

    // Full FIFO (16 ahead), drain across the MSB toggle.
    step(0, 0, 5'b11000, 0, 0, 16, 0, 5'b00000, 0);
    for (int k = 1; k <= 16; k++)
      step(1, 0, 5'b11000, (k == 16), (16 - k <= 2), 16 - k, k % 16, gray(k), 0);
    // Write pointer reaches 32 (wraps to 0); drain again so rbin wraps to 0.
    step(0, 0, 5'b00000, 0, 0, 16, 0, 5'b11000, 0);
    for (int k = 1; k <= 16; k++)
      step(1, 0, 5'b00000, (k == 16), (16 - k <= 2), 16 - k, k % 16, gray((16 + k) % 32), 0);
    step(1, 0, 5'b00000, 1, 1, 0, 0, 5'b00000, UF);
    step(1, 0, 5'b00000, 1, 1, 0, 0, 5'b00000, UF);
    step(1, 1, 5'b00000, 1, 1, 0, 0, 5'b00000, 0);
    step(0, 0, 5'b00000, 1, 1, 0, 0, 5'b00000, 0);

    repeat (4) @(posedge rclk);
    #3;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
